// File: rtl/stream_packer.sv
// Packs RATIO narrow elements into one wide word; closing element shows on data_out next cycle.
// Backpressure: while a word is held, input ready follows data_out_rdy so pop and refill share a cycle.
module stream_packer #(
  parameter int ELEM_WIDTH = 32,
  parameter int RATIO      = 4
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [ELEM_WIDTH-1:0]         data_in,
  input  logic                          data_in_val,
  input  logic                          data_in_last,
  output logic                          data_in_rdy,
  input  logic                          flush,
  output logic [RATIO*ELEM_WIDTH-1:0]   data_out,
  output logic [RATIO-1:0]              data_out_keep,
  output logic                          data_out_last,
  output logic                          data_out_val,
  input  logic                          data_out_rdy,
  output logic                          busy
);

  localparam int CNT_W = $clog2(RATIO);
  localparam int DW    = RATIO * ELEM_WIDTH;

  typedef enum logic {FILL, HOLD} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DW-1:0]       acc_q;
  logic [RATIO-1:0]    keep_q;
  logic                last_q;

  logic                accept;
  logic                pop;
  logic [DW-1:0]       acc_d;
  logic [RATIO-1:0]    keep_d;

  assign data_in_rdy   = (state_q == FILL) || data_out_rdy;
  assign accept        = data_in_val && data_in_rdy;
  assign data_out_val  = (state_q == HOLD);
  assign pop           = data_out_val && data_out_rdy;
  assign data_out      = acc_q;
  assign data_out_keep = keep_q;
  assign data_out_last = last_q;
  assign busy          = (state_q == HOLD) || (cnt_q != '0);

  // Accumulator with the incoming element dropped into the current slot.
  always_comb begin
    acc_d  = acc_q;
    keep_d = keep_q;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        acc_d[k*ELEM_WIDTH +: ELEM_WIDTH] = data_in;
        keep_d[k]                         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      acc_q   <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (state_q == FILL) begin
      if (accept) begin
        acc_q  <= acc_d;
        keep_q <= keep_d;
        if (cnt_q == CNT_W'(RATIO-1) || data_in_last || flush) begin
          state_q <= HOLD;
          last_q  <= data_in_last;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else if (flush && cnt_q != '0) begin
        state_q <= HOLD;
        last_q  <= 1'b0;
        cnt_q   <= '0;
      end
    end else if (pop) begin
      if (accept) begin
        // Refill slot 0 of a fresh word in the same cycle as the pop.
        acc_q  <= DW'(data_in);
        keep_q <= RATIO'(1);
        if (data_in_last) begin
          state_q <= HOLD;
          last_q  <= 1'b1;
          cnt_q   <= '0;
        end else begin
          state_q <= FILL;
          last_q  <= 1'b0;
          cnt_q   <= CNT_W'(1);
        end
      end else begin
        state_q <= FILL;
        acc_q   <= '0;
        keep_q  <= '0;
        last_q  <= 1'b0;
        cnt_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stream_packer.sv
// Directed table-driven bench for stream_packer (RATIO=4, ELEM_WIDTH=32) plus streaming and reset sequences.
module tb_stream_packer;

  localparam int EW = 32;
  localparam int R  = 4;
  localparam int DW = EW * R;

  logic          clk;
  logic          arst;
  logic [EW-1:0] data_in;
  logic          data_in_val;
  logic          data_in_last;
  logic          data_in_rdy;
  logic          flush;
  logic [DW-1:0] data_out;
  logic [R-1:0]  data_out_keep;
  logic          data_out_last;
  logic          data_out_val;
  logic          data_out_rdy;
  logic          busy;

  stream_packer #(.ELEM_WIDTH(EW), .RATIO(R)) dut (
    .clk           (clk),
    .arst          (arst),
    .data_in       (data_in),
    .data_in_val   (data_in_val),
    .data_in_last  (data_in_last),
    .data_in_rdy   (data_in_rdy),
    .flush         (flush),
    .data_out      (data_out),
    .data_out_keep (data_out_keep),
    .data_out_last (data_out_last),
    .data_out_val  (data_out_val),
    .data_out_rdy  (data_out_rdy),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied for one cycle, and outputs expected mid-cycle (before the edge that consumes them).
  typedef struct {
    logic [EW-1:0] din;
    logic          val;
    logic          last;
    logic          fl;
    logic          ordy;
    logic          e_val;
    logic [DW-1:0] e_data;
    logic [R-1:0]  e_keep;
    logic          e_last;
    logic          e_irdy;
    logic          e_busy;
  } vec_t;

  vec_t vt[$];
  int   pass_cnt = 0;
  int   total    = 0;

  function automatic vec_t mk(logic [EW-1:0] din, logic val, logic last, logic fl, logic ordy,
                              logic e_val, logic [DW-1:0] e_data, logic [R-1:0] e_keep,
                              logic e_last, logic e_irdy, logic e_busy);
    vec_t v;
    v.din = din; v.val = val; v.last = last; v.fl = fl; v.ordy = ordy;
    v.e_val = e_val; v.e_data = e_data; v.e_keep = e_keep; v.e_last = e_last;
    v.e_irdy = e_irdy; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic [EW-1:0] d, input logic v, input logic l, input logic f, input logic r);
    data_in      = d;
    data_in_val  = v;
    data_in_last = l;
    flush        = f;
    data_out_rdy = r;
  endtask

  // {val, data, keep, last, in_rdy, busy}; word fields only matter while a word is offered.
  function automatic logic [255:0] pack_obs(logic v, logic [DW-1:0] d, logic [R-1:0] k,
                                            logic l, logic ir, logic b);
    if (!v) begin
      d = '0; k = '0; l = 1'b0;
    end
    return 256'({v, d, k, l, ir, b});
  endfunction

  localparam logic [DW-1:0] W_1234 = 128'h00000004_00000003_00000002_00000001;

  initial begin
    logic [DW-1:0] w;

    // Test 1: full word 0x11..0x44, pops the cycle it appears.
    vt.push_back(mk(32'h11, 1, 0, 0, 1, 0, '0, '0, 0, 1, 0));
    vt.push_back(mk(32'h22, 1, 0, 0, 1, 0, '0, '0, 0, 1, 1));
    vt.push_back(mk(32'h33, 1, 0, 0, 1, 0, '0, '0, 0, 1, 1));
    vt.push_back(mk(32'h44, 1, 0, 0, 1, 0, '0, '0, 0, 1, 1));
    vt.push_back(mk(32'h0,  0, 0, 0, 1, 1, 128'h00000044_00000033_00000022_00000011, 4'b1111, 0, 1, 1));
    vt.push_back(mk(32'h0,  0, 0, 0, 1, 0, '0, '0, 0, 1, 0));
    // Test 2: short packet closed by last; next element starts a fresh word.
    vt.push_back(mk(32'hA,  1, 0, 0, 1, 0, '0, '0, 0, 1, 0));
    vt.push_back(mk(32'hB,  1, 1, 0, 1, 0, '0, '0, 0, 1, 1));
    vt.push_back(mk(32'hC,  1, 0, 0, 1, 1, 128'h0000000B_0000000A, 4'b0011, 1, 1, 1));
    vt.push_back(mk(32'h0,  0, 0, 0, 1, 0, '0, '0, 0, 1, 1));
    vt.push_back(mk(32'h0,  0, 0, 1, 1, 0, '0, '0, 0, 1, 1));
    vt.push_back(mk(32'h0,  0, 0, 0, 1, 1, 128'h0000000C, 4'b0001, 0, 1, 1));
    vt.push_back(mk(32'h0,  0, 0, 0, 1, 0, '0, '0, 0, 1, 0));
    // Test 3: backpressure for 5 cycles (flush in HOLD ignored), then pop plus refill.
    vt.push_back(mk(32'h1,  1, 0, 0, 1, 0, '0, '0, 0, 1, 0));
    vt.push_back(mk(32'h2,  1, 0, 0, 1, 0, '0, '0, 0, 1, 1));
    vt.push_back(mk(32'h3,  1, 0, 0, 1, 0, '0, '0, 0, 1, 1));
    vt.push_back(mk(32'h4,  1, 0, 0, 1, 0, '0, '0, 0, 1, 1));
    vt.push_back(mk(32'h5,  1, 0, 0, 0, 1, W_1234, 4'b1111, 0, 0, 1));
    vt.push_back(mk(32'h5,  1, 0, 0, 0, 1, W_1234, 4'b1111, 0, 0, 1));
    vt.push_back(mk(32'h5,  1, 0, 1, 0, 1, W_1234, 4'b1111, 0, 0, 1));
    vt.push_back(mk(32'h5,  1, 0, 0, 0, 1, W_1234, 4'b1111, 0, 0, 1));
    vt.push_back(mk(32'h5,  1, 0, 0, 0, 1, W_1234, 4'b1111, 0, 0, 1));
    vt.push_back(mk(32'h5,  1, 0, 0, 1, 1, W_1234, 4'b1111, 0, 1, 1));
    vt.push_back(mk(32'h0,  0, 0, 0, 1, 0, '0, '0, 0, 1, 1));
    // Test 4: flush with 3 elements, then flush on an empty packer.
    vt.push_back(mk(32'h6,  1, 0, 0, 1, 0, '0, '0, 0, 1, 1));
    vt.push_back(mk(32'h7,  1, 0, 0, 1, 0, '0, '0, 0, 1, 1));
    vt.push_back(mk(32'h0,  0, 0, 1, 1, 0, '0, '0, 0, 1, 1));
    vt.push_back(mk(32'h0,  0, 0, 0, 1, 1, 128'h00000007_00000006_00000005, 4'b0111, 0, 1, 1));
    vt.push_back(mk(32'h0,  0, 0, 0, 1, 0, '0, '0, 0, 1, 0));
    vt.push_back(mk(32'h0,  0, 0, 1, 1, 0, '0, '0, 0, 1, 0));
    vt.push_back(mk(32'h0,  0, 0, 0, 1, 0, '0, '0, 0, 1, 0));
    // Flush coincident with an accept keeps the element.
    vt.push_back(mk(32'h8,  1, 0, 1, 1, 0, '0, '0, 0, 1, 0));
    vt.push_back(mk(32'h0,  0, 0, 0, 1, 1, 128'h00000008, 4'b0001, 0, 1, 1));
    vt.push_back(mk(32'h0,  0, 0, 0, 1, 0, '0, '0, 0, 1, 0));
    // Last-flagged element arriving on a pop goes straight back to HOLD.
    vt.push_back(mk(32'h9,  1, 0, 0, 1, 0, '0, '0, 0, 1, 0));
    vt.push_back(mk(32'hA,  1, 1, 0, 1, 0, '0, '0, 0, 1, 1));
    vt.push_back(mk(32'hB,  1, 1, 0, 1, 1, 128'h0000000A_00000009, 4'b0011, 1, 1, 1));
    vt.push_back(mk(32'h0,  0, 0, 0, 1, 1, 128'h0000000B, 4'b0001, 1, 1, 1));
    vt.push_back(mk(32'h0,  0, 0, 0, 1, 0, '0, '0, 0, 1, 0));
    // Last without valid does nothing.
    vt.push_back(mk(32'hF,  0, 1, 0, 1, 0, '0, '0, 0, 1, 0));
    vt.push_back(mk(32'h0,  0, 0, 0, 1, 0, '0, '0, 0, 1, 0));

    arst = 1'b1;
    drive('0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    chk("reset_state", pack_obs(data_out_val, data_out, data_out_keep, data_out_last, data_in_rdy, busy),
        256'({1'b0, {DW{1'b0}}, 4'b0000, 1'b0, 1'b1, 1'b0}));
    chk("reset_data", 256'({data_out, data_out_keep, data_out_last}), 256'(0));
    arst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      drive(vt[i].din, vt[i].val, vt[i].last, vt[i].fl, vt[i].ordy);
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          pack_obs(data_out_val, data_out, data_out_keep, data_out_last, data_in_rdy, busy),
          pack_obs(vt[i].e_val, vt[i].e_data, vt[i].e_keep, vt[i].e_last, vt[i].e_irdy, vt[i].e_busy));
    end

    // Continuous stream of 16 elements: a word every 4th cycle, ready never drops.
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      if (i < 16) drive(32'h100 + i, 1, 0, 0, 1);
      else        drive('0, 0, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("stream_rdy%0d", i), 256'(data_in_rdy), 256'(1));
      chk($sformatf("stream_val%0d", i), 256'(data_out_val), 256'((i > 0) && (i % 4 == 0)));
      if ((i > 0) && (i % 4 == 0)) begin
        for (int k = 0; k < R; k++) w[k*EW +: EW] = 32'h100 + 32'((i/4 - 1)*4 + k);
        chk($sformatf("stream_word%0d", i/4 - 1), 256'({data_out, data_out_keep, data_out_last}),
            256'({w, 4'b1111, 1'b0}));
      end
    end

    // Asynchronous reset mid-word discards the partial word.
    @(posedge clk); #1; drive(32'hDE, 1, 0, 0, 1);
    @(posedge clk); #1; drive(32'hAD, 1, 0, 0, 1);
    @(posedge clk); #1; drive('0, 0, 0, 0, 1);
    @(negedge clk);
    chk("pre_reset_busy", 256'(busy), 256'(1));
    arst = 1'b1;
    #1;
    chk("async_reset", pack_obs(1'b1, data_out, data_out_keep, data_out_last, data_in_rdy, busy)
        | 256'(data_out_val) << 200,
        256'({1'b1, {DW{1'b0}}, 4'b0000, 1'b0, 1'b1, 1'b0}));
    @(negedge clk);
    arst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; drive(32'h51 + i, 1, 0, 0, 1);
    end
    @(posedge clk); #1; drive('0, 0, 0, 0, 1);
    @(negedge clk);
    chk("post_reset_word", pack_obs(data_out_val, data_out, data_out_keep, data_out_last, data_in_rdy, busy),
        pack_obs(1'b1, 128'h00000054_00000053_00000052_00000051, 4'b1111, 1'b0, 1'b1, 1'b1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_reset_idle", 256'({data_out_val, busy}), 256'(0));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
